// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
// Op codes, FSM states and small decode helpers.
package muldiv_pkg;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;

  function automatic logic op_is_div(input logic [1:0] o);
    return o[1];
  endfunction

  function automatic logic op_is_signed(input logic [1:0] o);
    return ~o[0];
  endfunction

  function automatic int unsigned cnt_width(input int unsigned w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add multiply or
// restoring shift-subtract divide.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic             div_i,
  input  logic [WIDTH:0]   acc_i,
  input  logic [WIDTH:0]   opnd_i,
  input  logic [WIDTH-1:0] q_i,
  output logic [WIDTH:0]   acc_o,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   sh;
  logic [WIDTH+1:0] diff;

  // Both step flavours computed; mode selects which is committed
  always_comb begin
    sum  = q_i[0] ? (acc_i + opnd_i) : acc_i;
    sh   = {acc_i[WIDTH-1:0], q_i[WIDTH-1]};
    diff = {1'b0, sh} - {1'b0, opnd_i};
    if (div_i) begin
      acc_o = diff[WIDTH+1] ? sh : diff[WIDTH:0];
      q_o   = {q_i[WIDTH-2:0], ~diff[WIDTH+1]};
    end else begin
      acc_o = {1'b0, sum[WIDTH:1]};
      q_o   = {sum[0], q_i[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO.
// Magnitude datapath with sign fix-up in a final cycle.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             dz,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = cnt_width(WIDTH);

  logic [1:0]         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               div_q, div_d;
  logic               psign_q, psign_d;
  logic               rsign_q, rsign_d;
  logic               bz_q, bz_d;
  logic [WIDTH:0]     acc_q, acc_d;
  logic [WIDTH:0]     opnd_q, opnd_d;
  logic [WIDTH-1:0]   qr_q, qr_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;
  logic               dz_q, dz_d;

  logic               op_sgn;
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH:0]     acc_nx;
  logic [WIDTH-1:0]   qr_nx;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  assign op_sgn = op_is_signed(op);
  assign a_neg  = op_sgn & a[WIDTH-1];
  assign b_neg  = op_sgn & b[WIDTH-1];
  assign a_mag  = a_neg ? -a : a;
  assign b_mag  = b_neg ? -b : b;

  assign prod     = {acc_q[WIDTH-1:0], qr_q};
  assign prod_fix = psign_q ? -prod : prod;
  assign quo_fix  = psign_q ? -qr_q : qr_q;
  assign rem_fix  = rsign_q ? -acc_q[WIDTH-1:0]
                            : acc_q[WIDTH-1:0];

  muldiv_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .div_i  (div_q),
    .acc_i  (acc_q),
    .opnd_i (opnd_q),
    .q_i    (qr_q),
    .acc_o  (acc_nx),
    .q_o    (qr_nx)
  );

  // FSM, operand latching, iteration and HI/LO update
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    psign_d = psign_q;
    rsign_d = rsign_q;
    bz_d    = bz_q;
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    qr_d    = qr_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    dz_d    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (hi_we) hi_d = wdata;
        if (lo_we) lo_d = wdata;
        if (start) begin
          state_d = ST_RUN;
          cnt_d   = '0;
          div_d   = op_is_div(op);
          psign_d = a_neg ^ b_neg;
          rsign_d = a_neg;
          bz_d    = op_is_div(op) & (b == '0);
          acc_d   = '0;
          if (op_is_div(op)) begin
            qr_d   = a_mag;
            opnd_d = {1'b0, b_mag};
          end else begin
            qr_d   = b_mag;
            opnd_d = {1'b0, a_mag};
          end
        end
      end
      ST_RUN: begin
        acc_d = acc_nx;
        qr_d  = qr_nx;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = ST_FIX;
          cnt_d   = '0;
        end
      end
      ST_FIX: begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
        dz_d    = bz_q;
        if (div_q) begin
          lo_d = bz_q ? '1 : quo_fix;
          hi_d = rem_fix;
        end else begin
          {hi_d, lo_d} = prod_fix;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      div_q   <= 1'b0;
      psign_q <= 1'b0;
      rsign_q <= 1'b0;
      bz_q    <= 1'b0;
      acc_q   <= '0;
      opnd_q  <= '0;
      qr_q    <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      psign_q <= psign_d;
      rsign_q <= rsign_d;
      bz_q    <= bz_d;
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
      qr_q    <= qr_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
    end
  end

  assign busy = (state_q != ST_IDLE);
  assign done = done_q;
  assign dz   = dz_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit.
// Directed cases plus random ops against an arithmetic model.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        dz;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int errors = 0;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .hi_we (hi_we),
    .lo_we (lo_we),
    .wdata (wdata),
    .busy  (busy),
    .done  (done),
    .dz    (dz),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  function automatic void model(
    input  logic [1:0]  o,
    input  logic [31:0] av,
    input  logic [31:0] bv,
    output logic [31:0] eh,
    output logic [31:0] el,
    output logic        ez
  );
    longint      p;
    logic [63:0] u;
    int          sa;
    int          sb;
    ez = 1'b0;
    eh = '0;
    el = '0;
    case (o)
      2'b00: begin
        p  = longint'($signed(av)) * longint'($signed(bv));
        eh = p[63:32];
        el = p[31:0];
      end
      2'b01: begin
        u  = 64'(av) * 64'(bv);
        eh = u[63:32];
        el = u[31:0];
      end
      default: begin
        if (bv == 0) begin
          el = '1;
          eh = av;
          ez = 1'b1;
        end else if (o == 2'b11) begin
          el = av / bv;
          eh = av % bv;
        end else if (av == 32'h8000_0000 && bv == 32'hFFFF_FFFF) begin
          el = av;
          eh = '0;
        end else begin
          sa = av;
          sb = bv;
          el = sa / sb;
          eh = sa % sb;
        end
      end
    endcase
  endfunction

  // Issue one op from an idle cycle and wait (bounded) for done.
  task automatic do_op(
    input  logic [1:0]  o,
    input  logic [31:0] av,
    input  logic [31:0] bv,
    input  bit          mid,
    output int          n,
    output logic [31:0] rh,
    output logic [31:0] rl,
    output logic        rz,
    output logic        bs,
    output logic        bd,
    output logic [31:0] hs,
    output logic [31:0] hm
  );
    op = o;
    a = av;
    b = bv;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    hi_we = 1'b0;
    lo_we = 1'b0;
    op = 2'($urandom);
    a = $urandom;
    b = $urandom;
    bs = busy;
    hs = hi;
    hm = hi;
    n = 0;
    while (n < 40) begin
      if (mid && n == 5) begin
        hi_we = 1'b1;
        lo_we = 1'b1;
        wdata = $urandom;
        start = 1'b1;
      end
      @(posedge clk); #1;
      n++;
      if (mid && n == 6) begin
        hi_we = 1'b0;
        lo_we = 1'b0;
        start = 1'b0;
        hm = hi;
      end
      if (done) break;
    end
    rh = hi;
    rl = lo;
    rz = dz;
    bd = busy;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    op = '0;
    a = '0;
    b = '0;
    hi_we = 1'b0;
    lo_we = 1'b0;
    wdata = '0;
    #12;
    checks++;
    if ({busy, done, dz, hi, lo} !== 67'd0) begin
      errors++;
      $display("FAIL reset: got busy=%b done=%b dz=%b hi=%h lo=%h want all 0",
               busy, done, dz, hi, lo);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_mul();
    int n;
    logic [31:0] rh, rl, hs, hm;
    logic rz, bs, bd;
    do_op(2'b00, 32'hFFFF_FFFD, 32'd7, 0, n, rh, rl, rz, bs, bd, hs, hm);
    checks++;
    if (n !== 33 || bs !== 1'b1 || bd !== 1'b0) begin
      errors++;
      $display("FAIL mult_timing: got n=%0d busy_start=%b busy_done=%b want 33 1 0",
               n, bs, bd);
    end
    checks++;
    if ({rh, rl, rz} !== {32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0}) begin
      errors++;
      $display("FAIL mult_neg: got hi=%h lo=%h dz=%b want ffffffff ffffffeb 0",
               rh, rl, rz);
    end
    do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, n, rh, rl, rz, bs, bd, hs, hm);
    checks++;
    if ({rh, rl} !== {32'hFFFF_FFFE, 32'h0000_0001} || n !== 33) begin
      errors++;
      $display("FAIL multu_max: got hi=%h lo=%h n=%0d want fffffffe 00000001 33",
               rh, rl, n);
    end
    do_op(2'b01, 32'd5, 32'd6, 0, n, rh, rl, rz, bs, bd, hs, hm);
    checks++;
    if ({rh, rl} !== {32'd0, 32'd30} || n !== 33 || bs !== 1'b1) begin
      errors++;
      $display("FAIL back_to_back: got hi=%h lo=%h n=%0d busy=%b want 0 1e 33 1",
               rh, rl, n, bs);
    end
  endtask

  task automatic test_div();
    int n;
    logic [31:0] rh, rl, hs, hm;
    logic rz, bs, bd;
    do_op(2'b10, 32'hFFFF_FFF9, 32'd2, 0, n, rh, rl, rz, bs, bd, hs, hm);
    checks++;
    if ({rh, rl, rz} !== {32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0} || n !== 33) begin
      errors++;
      $display("FAIL div_neg: got hi=%h lo=%h dz=%b n=%0d want ffffffff fffffffd 0 33",
               rh, rl, rz, n);
    end
    do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, n, rh, rl, rz, bs, bd, hs, hm);
    checks++;
    if ({rh, rl, rz} !== {32'h0, 32'h8000_0000, 1'b0}) begin
      errors++;
      $display("FAIL div_ovf: got hi=%h lo=%h dz=%b want 0 80000000 0",
               rh, rl, rz);
    end
    do_op(2'b11, 32'd100, 32'd0, 0, n, rh, rl, rz, bs, bd, hs, hm);
    checks++;
    if ({rh, rl, rz} !== {32'd100, 32'hFFFF_FFFF, 1'b1} || n !== 33) begin
      errors++;
      $display("FAIL divu_zero: got hi=%h lo=%h dz=%b n=%0d want 64 ffffffff 1 33",
               rh, rl, rz, n);
    end
    @(posedge clk); #1;
    checks++;
    if (dz !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL dz_pulse: got dz=%b done=%b next cycle want 0 0", dz, done);
    end
  endtask

  task automatic test_hilo_write();
    int n;
    logic [31:0] rh, rl, hs, hm;
    logic rz, bs, bd;
    hi_we = 1'b1;
    wdata = 32'h0000_1234;
    @(posedge clk); #1;
    hi_we = 1'b0;
    checks++;
    if (hi !== 32'h0000_1234) begin
      errors++;
      $display("FAIL mthi_idle: got hi=%h want 00001234", hi);
    end
    hi_we = 1'b1;
    wdata = 32'h0000_ABCD;
    do_op(2'b01, 32'd2, 32'd3, 0, n, rh, rl, rz, bs, bd, hs, hm);
    checks++;
    if (hs !== 32'h0000_ABCD) begin
      errors++;
      $display("FAIL mthi_with_start: got hi=%h want 0000abcd", hs);
    end
    checks++;
    if ({rh, rl} !== {32'd0, 32'd6}) begin
      errors++;
      $display("FAIL start_overwrite: got hi=%h lo=%h want 0 6", rh, rl);
    end
    do_op(2'b01, 32'd7, 32'd9, 1, n, rh, rl, rz, bs, bd, hs, hm);
    checks++;
    if (hm !== hs) begin
      errors++;
      $display("FAIL mthi_busy: got hi=%h want %h", hm, hs);
    end
    checks++;
    if ({rh, rl} !== {32'd0, 32'd63} || n !== 33) begin
      errors++;
      $display("FAIL restart_ignored: got hi=%h lo=%h n=%0d want 0 3f 33",
               rh, rl, n);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    int nd;
    logic [31:0] rh, rl, hs, hm, eh, el, av, bv;
    logic rz, bs, bd, ez;
    lo_we = 1'b1;
    wdata = 32'h0000_0088;
    @(posedge clk); #1;
    lo_we = 1'b0;
    checks++;
    if (lo !== 32'h0000_0088) begin
      errors++;
      $display("FAIL mtlo_idle: got lo=%h want 00000088", lo);
    end
    op = 2'b11;
    a = $urandom;
    b = $urandom | 32'd1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, hi, lo} !== 66'd0) begin
      errors++;
      $display("FAIL reset_mid: got busy=%b done=%b hi=%h lo=%h want 0",
               busy, done, hi, lo);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    nd = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done) nd++;
    end
    checks++;
    if (nd !== 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL no_done_after_reset: got dones=%0d busy=%b want 0 0",
               nd, busy);
    end
    av = $urandom;
    bv = $urandom;
    model(2'b00, av, bv, eh, el, ez);
    do_op(2'b00, av, bv, 0, n, rh, rl, rz, bs, bd, hs, hm);
    checks++;
    if ({rh, rl, rz} !== {eh, el, ez} || n !== 33) begin
      errors++;
      $display("FAIL post_reset_op: got hi=%h lo=%h n=%0d want %h %h 33",
               rh, rl, n, eh, el);
    end
  endtask

  task automatic test_random();
    int n;
    logic [31:0] rh, rl, hs, hm, eh, el, av, bv;
    logic [1:0] o;
    logic rz, bs, bd, ez;
    for (int i = 0; i < 60; i++) begin
      o = 2'($urandom);
      av = $urandom;
      bv = $urandom;
      case ($urandom % 8)
        0: bv = '0;
        1: begin av = 32'h8000_0000; bv = 32'hFFFF_FFFF; end
        2: begin av = $urandom % 200; bv = $urandom % 13; end
        3: av = 32'h8000_0000;
        default: ;
      endcase
      model(o, av, bv, eh, el, ez);
      do_op(o, av, bv, 0, n, rh, rl, rz, bs, bd, hs, hm);
      checks++;
      if ({rh, rl, rz, bd} !== {eh, el, ez, 1'b0} || n !== 33) begin
        errors++;
        $display("FAIL random op=%0d a=%h b=%h: got hi=%h lo=%h dz=%b busy=%b n=%0d want %h %h %b 0 33",
                 o, av, bv, rh, rl, rz, bd, n, eh, el, ez);
      end
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_hilo_write();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
